// File: rtl/rpc_reg_mux_pkg.sv
// rpc_reg_mux_pkg: shared types, request/response typedef macros and the channel decode helper
`define RPC_REG_MUX_TYPEDEF_REQ(req_t, AW, DW) \
    typedef struct packed { \
        logic [AW-1:0]     addr; \
        logic              write; \
        logic [DW-1:0]     wdata; \
        logic [DW/8-1:0]   wstrb; \
    } req_t;

`define RPC_REG_MUX_TYPEDEF_RSP(rsp_t, DW) \
    typedef struct packed { \
        logic [DW-1:0]     rdata; \
        logic              error; \
    } rsp_t;

package rpc_reg_mux_pkg;

    localparam int MaxChSelW = 4;
    localparam int DecW      = MaxChSelW + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // Returns {hit, idx}; idx is zero-extended to MaxChSelW bits.
    function automatic logic [DecW-1:0] rpc_decode(
        input logic [63:0] addr,
        input int          sel_lsb,
        input int          sel_w,
        input int          num_ch,
        input logic [63:0] base
    );
        logic [63:0] idx;
        logic        hit;
        idx = (addr >> sel_lsb) & ((64'd1 << sel_w) - 64'd1);
        hit = ((addr >> (sel_lsb + sel_w)) == (base >> (sel_lsb + sel_w))) && (idx < 64'(num_ch));
        return {hit, idx[DecW-2:0]};
    endfunction

endpackage

// File: rtl/rpc_reg_mux_timeout.sv
// rpc_reg_mux_timeout: wait-cycle counter that flags expiry on its last permitted cycle
module rpc_reg_mux_timeout #(
    parameter int Cycles = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CntW = (Cycles > 1) ? $clog2(Cycles) : 1;

    if (Cycles == 0) begin : g_off
        assign expired_o = 1'b0;
    end else begin : g_cnt
        logic [CntW-1:0] cnt_q, cnt_d;
        assign expired_o = en_i && (cnt_q == CntW'(Cycles - 1));
        // Count enabled cycles; restart when cleared or once expired.
        always_comb cnt_d = (clr_i || expired_o) ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
        // Counter register with synchronous reset.
        always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
    end

endmodule

// File: rtl/rpc_reg_mux.sv
// rpc_reg_mux: reg-bus channel demux with decode errors and timeout; RPC_REG_MUX_ERR_STICKY_EN adds per-channel sticky error flags
module rpc_reg_mux
    import rpc_reg_mux_pkg::*;
#(
    parameter int                     NumChannels   = 4,
    parameter int                     RegAddrWidth  = 48,
    parameter int                     RegDataWidth  = 32,
    parameter int                     ChSelLsb      = 12,
    parameter logic [RegAddrWidth-1:0] BaseAddr     = '0,
    parameter int                     TimeoutCycles = 256
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [RegAddrWidth-1:0]             reg_addr_i,
    input  logic                                reg_write_i,
    input  logic [RegDataWidth-1:0]             reg_wdata_i,
    input  logic [RegDataWidth/8-1:0]           reg_wstrb_i,
    input  logic                                reg_valid_i,
    output logic [RegDataWidth-1:0]             reg_rdata_o,
    output logic                                reg_error_o,
    output logic                                reg_ready_o,
    output logic [RegAddrWidth-1:0]             ch_addr_o,
    output logic                                ch_write_o,
    output logic [RegDataWidth-1:0]             ch_wdata_o,
    output logic [RegDataWidth/8-1:0]           ch_wstrb_o,
    output logic [NumChannels-1:0]              ch_valid_o,
    input  logic [NumChannels*RegDataWidth-1:0] ch_rdata_i,
    input  logic [NumChannels-1:0]              ch_ready_i,
    input  logic [NumChannels-1:0]              ch_error_i
`ifdef RPC_REG_MUX_ERR_STICKY_EN
   ,output logic [NumChannels-1:0]              err_sticky_o,
    input  logic [NumChannels-1:0]              err_clr_i
`endif
);

    localparam int ChSelW = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam logic [RegAddrWidth-1:0] OffMask = (RegAddrWidth'(1) << ChSelLsb) - RegAddrWidth'(1);

    `RPC_REG_MUX_TYPEDEF_REQ(req_t, RegAddrWidth, RegDataWidth)
    `RPC_REG_MUX_TYPEDEF_RSP(rsp_t, RegDataWidth)

    state_e                  state_q, state_d;
    req_t                    req_q, req_d;
    rsp_t                    rsp_q, rsp_d;
    logic [ChSelW-1:0]       idx_q, idx_d;
    logic [DecW-1:0]         dec;
    logic                    hit;
    logic [ChSelW-1:0]       dec_idx;
    logic                    in_wait;
    logic                    sel_ready;
    logic                    expired;
    logic [NumChannels-1:0]  sel_oh;
    logic [RegDataWidth-1:0] sel_rdata;

    assign dec       = rpc_decode(64'(reg_addr_i), ChSelLsb, ChSelW, NumChannels, 64'(BaseAddr));
    assign hit       = dec[DecW-1];
    assign dec_idx   = ChSelW'(dec[DecW-2:0]);
    assign in_wait   = (state_q == WAIT);
    assign sel_ready = ch_ready_i[idx_q];
    assign sel_oh    = NumChannels'(1) << idx_q;
    assign sel_rdata = ch_rdata_i[32'(idx_q) * RegDataWidth +: RegDataWidth];

    assign reg_ready_o = (state_q == RESP);
    assign reg_rdata_o = rsp_q.rdata;
    assign reg_error_o = rsp_q.error;
    assign ch_addr_o   = req_q.addr & OffMask;
    assign ch_write_o  = req_q.write;
    assign ch_wdata_o  = req_q.wdata;
    assign ch_wstrb_o  = req_q.wstrb;
    assign ch_valid_o  = in_wait ? sel_oh : '0;

    rpc_reg_mux_timeout #(
        .Cycles(TimeoutCycles)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (!in_wait),
        .en_i     (in_wait && !sel_ready),
        .expired_o(expired)
    );

    // Next state: capture and decode in IDLE, wait for channel ready or timeout, respond once.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rsp_d   = rsp_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: if (reg_valid_i) begin
                req_d.addr  = reg_addr_i;
                req_d.write = reg_write_i;
                req_d.wdata = reg_wdata_i;
                req_d.wstrb = reg_wstrb_i;
                idx_d       = dec_idx;
                rsp_d       = '{rdata: '0, error: !hit};
                state_d     = hit ? WAIT : RESP;
            end
            WAIT: if (sel_ready) begin
                rsp_d   = '{rdata: req_q.write ? '0 : sel_rdata, error: ch_error_i[idx_q]};
                state_d = RESP;
            end else if (expired) begin
                rsp_d   = '{rdata: '0, error: 1'b1};
                state_d = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and captured request/response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            req_q   <= '0;
            rsp_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rsp_q   <= rsp_d;
            idx_q   <= idx_d;
        end
    end

`ifdef RPC_REG_MUX_ERR_STICKY_EN
    logic [NumChannels-1:0] sticky_q, sticky_set;
    assign sticky_set   = (in_wait && ((sel_ready && ch_error_i[idx_q]) || expired)) ? sel_oh : '0;
    assign err_sticky_o = sticky_q;
    // Sticky error flags; a new error wins over a simultaneous clear.
    always_ff @(posedge clk_i) sticky_q <= rst_i ? '0 : (sticky_q & ~err_clr_i) | sticky_set;
`endif

endmodule

// File: tb/tb_rpc_reg_mux.sv
// tb_rpc_reg_mux: randomized self-checking bench for rpc_reg_mux against a transaction-level model
module tb_rpc_reg_mux;

    localparam int NCH  = 3;
    localparam int AW   = 48;
    localparam int DW   = 32;
    localparam int TMO  = 8;
    localparam logic [AW-1:0] BASE = '0;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [AW-1:0]     reg_addr_i;
    logic              reg_write_i;
    logic [DW-1:0]     reg_wdata_i;
    logic [DW/8-1:0]   reg_wstrb_i;
    logic              reg_valid_i;
    logic [DW-1:0]     reg_rdata_o;
    logic              reg_error_o;
    logic              reg_ready_o;
    logic [AW-1:0]     ch_addr_o;
    logic              ch_write_o;
    logic [DW-1:0]     ch_wdata_o;
    logic [DW/8-1:0]   ch_wstrb_o;
    logic [NCH-1:0]    ch_valid_o;
    logic [NCH*DW-1:0] ch_rdata_i;
    logic [NCH-1:0]    ch_ready_i;
    logic [NCH-1:0]    ch_error_i;
`ifdef RPC_REG_MUX_ERR_STICKY_EN
    logic [NCH-1:0]    err_sticky_o;
    logic [NCH-1:0]    err_clr_i;
`endif

    int             n_checks = 0;
    int             n_fail   = 0;
    logic [NCH-1:0] sticky_m = '0;

    always #5 clk = ~clk;

    rpc_reg_mux #(
        .NumChannels  (NCH),
        .RegAddrWidth (AW),
        .RegDataWidth (DW),
        .ChSelLsb     (12),
        .BaseAddr     (BASE),
        .TimeoutCycles(TMO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .reg_addr_i  (reg_addr_i),
        .reg_write_i (reg_write_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_wstrb_i (reg_wstrb_i),
        .reg_valid_i (reg_valid_i),
        .reg_rdata_o (reg_rdata_o),
        .reg_error_o (reg_error_o),
        .reg_ready_o (reg_ready_o),
        .ch_addr_o   (ch_addr_o),
        .ch_write_o  (ch_write_o),
        .ch_wdata_o  (ch_wdata_o),
        .ch_wstrb_o  (ch_wstrb_o),
        .ch_valid_o  (ch_valid_o),
        .ch_rdata_i  (ch_rdata_i),
        .ch_ready_i  (ch_ready_i),
        .ch_error_i  (ch_error_i)
`ifdef RPC_REG_MUX_ERR_STICKY_EN
       ,.err_sticky_o(err_sticky_o),
        .err_clr_i   (err_clr_i)
`endif
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_sticky();
`ifdef RPC_REG_MUX_ERR_STICKY_EN
        check("err_sticky", 64'(err_sticky_o), 64'(sticky_m));
`endif
    endtask

    // Drive the clear for the coming edge and advance the model across that edge.
    task automatic drive_sticky(input logic [NCH-1:0] clr, input logic [NCH-1:0] set);
`ifdef RPC_REG_MUX_ERR_STICKY_EN
        err_clr_i = clr;
`endif
        sticky_m = (sticky_m & ~clr) | set;
    endtask

    task automatic noise_channels();
        ch_ready_i = NCH'($urandom);
        ch_error_i = NCH'($urandom);
        ch_rdata_i = {$urandom, $urandom, $urandom};
    endtask

    // One upstream transaction; the selected channel answers on WAIT cycle lat (0 = never).
    task automatic run_txn(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                           input logic [DW/8-1:0] ws, input int lat, input logic [DW-1:0] rd,
                           input logic er);
        int             idx, wl, last;
        bit             hit, tmo;
        logic [NCH-1:0] oh, clr;
        idx  = int'((addr / 4096) % 4);
        hit  = ((addr / 16384) == (BASE / 16384)) && (idx < NCH);
        tmo  = hit && !(lat >= 1 && lat <= TMO);
        wl   = !hit ? 0 : tmo ? TMO : lat;
        last = hit ? wl + 2 : 2;
        oh   = hit ? NCH'(1 << idx) : '0;
        @(negedge clk);
        for (int n = 1; n <= last; n++) begin
            if (n > 1) @(negedge clk);
            check("ch_valid", 64'(ch_valid_o), (n >= 2 && n <= wl + 1) ? 64'(oh) : 64'd0);
            check("reg_ready", 64'(reg_ready_o), 64'(n == last));
            check_sticky();
            if (n == last) begin
                check("reg_rdata", 64'(reg_rdata_o), (tmo || !hit || wr) ? 64'd0 : 64'(rd));
                check("reg_error", 64'(reg_error_o), 64'(tmo || !hit || er));
            end
            if (hit && n == 2) begin
                check("ch_addr", 64'(ch_addr_o), 64'(addr % 4096));
                check("ch_write", 64'(ch_write_o), 64'(wr));
                check("ch_wdata", 64'(ch_wdata_o), 64'(wd));
                check("ch_wstrb", 64'(ch_wstrb_o), 64'(ws));
            end
            reg_valid_i = (n < last);
            if (n == 1) begin
                reg_addr_i  = addr;
                reg_write_i = wr;
                reg_wdata_i = wd;
                reg_wstrb_i = ws;
            end else begin
                reg_addr_i  = AW'({$urandom, $urandom});
                reg_write_i = 1'($urandom);
                reg_wdata_i = $urandom;
                reg_wstrb_i = 4'($urandom);
            end
            noise_channels();
            if (hit) begin
                ch_ready_i[idx]          = (n - 1 == lat);
                ch_error_i[idx]          = er;
                ch_rdata_i[idx*DW +: DW] = rd;
            end
            clr = ($urandom_range(3) == 0) ? NCH'($urandom) : '0;
            drive_sticky(clr, (hit && n == wl + 1 && (tmo || er)) ? oh : '0);
        end
    endtask

    task automatic idle(input logic [NCH-1:0] clr);
        @(negedge clk);
        check("idle_ready", 64'(reg_ready_o), 64'd0);
        check("idle_valid", 64'(ch_valid_o), 64'd0);
        check_sticky();
        reg_valid_i = 1'b0;
        noise_channels();
        drive_sticky(clr, '0);
    endtask

    task automatic reset_mid_wait();
        @(negedge clk);
        reg_valid_i = 1'b1;
        reg_addr_i  = 48'h2000;
        reg_write_i = 1'b0;
        ch_ready_i  = '0;
        drive_sticky('0, '0);
        repeat (2) begin
            @(negedge clk);
            check("pre_rst_valid", 64'(ch_valid_o), 64'b100);
        end
        rst_i       = 1'b1;
        reg_valid_i = 1'b0;
        @(negedge clk);
        rst_i    = 1'b0;
        sticky_m = '0;
        check("rst_valid", 64'(ch_valid_o), 64'd0);
        check("rst_ready", 64'(reg_ready_o), 64'd0);
        check("rst_rdata", 64'(reg_rdata_o), 64'd0);
        check("rst_error", 64'(reg_error_o), 64'd0);
        check("rst_addr", 64'(ch_addr_o), 64'd0);
        check("rst_write", 64'(ch_write_o), 64'd0);
        check("rst_wdata", 64'(ch_wdata_o), 64'd0);
        check("rst_wstrb", 64'(ch_wstrb_o), 64'd0);
        check_sticky();
        idle('0);
        idle('0);
    endtask

    initial begin
        rst_i       = 1'b1;
        reg_valid_i = 1'b0;
        reg_addr_i  = '0;
        reg_write_i = 1'b0;
        reg_wdata_i = '0;
        reg_wstrb_i = '0;
        ch_rdata_i  = '0;
        ch_ready_i  = '0;
        ch_error_i  = '0;
        drive_sticky('0, '0);
        sticky_m = '0;
        repeat (2) @(negedge clk);
        check("init_ready", 64'(reg_ready_o), 64'd0);
        check("init_valid", 64'(ch_valid_o), 64'd0);
        check("init_rdata", 64'(reg_rdata_o), 64'd0);
        check("init_error", 64'(reg_error_o), 64'd0);
        check("init_addr", 64'(ch_addr_o), 64'd0);
        check_sticky();
        rst_i = 1'b0;
        run_txn(48'h2010, 1'b0, 32'h0, 4'h0, 1, 32'hDEADBEEF, 1'b0);
        run_txn(48'h0004, 1'b1, 32'h12345678, 4'b0011, 1, 32'hCAFEF00D, 1'b0);
        run_txn(48'h3000, 1'b0, 32'h0, 4'h0, 1, 32'h11111111, 1'b0);
        run_txn(48'h1_0000_2000, 1'b0, 32'h0, 4'h0, 1, 32'h22222222, 1'b0);
        run_txn(48'h1000, 1'b0, 32'h0, 4'h0, 0, 32'h33333333, 1'b0);
        idle('0);
        idle(3'b010);
        idle('0);
        run_txn(48'h1000, 1'b0, 32'h0, 4'h0, TMO, 32'h44444444, 1'b0);
        run_txn(48'h0ffc, 1'b0, 32'h0, 4'h0, 3, 32'h55555555, 1'b1);
        run_txn(48'h1008, 1'b1, 32'hA5A5A5A5, 4'b0000, 2, 32'h66666666, 1'b0);
        reset_mid_wait();
        run_txn(48'h2020, 1'b0, 32'h0, 4'h0, 1, 32'h77777777, 1'b0);
        for (int i = 0; i < 150; i++) begin
            logic [AW-1:0] a;
            a = (AW'($urandom_range(3)) << 12) | AW'($urandom_range(4095));
            if ($urandom_range(9) == 0) a = a | (AW'($urandom_range(255, 1)) << 14);
            run_txn(a, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(10)), $urandom,
                    $urandom_range(3) == 0);
            if ($urandom_range(3) == 0) idle(NCH'($urandom));
        end
        idle('0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
